// File: rtl/flash_cell_read_channel_pkg.sv
// Shared types, sizes and arithmetic helpers for the flash cell read channel.
package flash_chan_pkg;

  localparam int DW         = 16;
  localparam int LEVELS     = 4;
  localparam int LW         = $clog2(LEVELS);
  localparam int FIFO_PAIRS = 4;
  localparam int CNT_W      = 32;

  typedef logic signed [DW-1:0]     vth_t;
  typedef logic [LW-1:0]            lvl_t;
  typedef logic [(LEVELS-1)*DW-1:0] refs_t;

  // Signed add with the sum clamped to the representable vth_t range.
  function automatic vth_t sat_add(vth_t a, vth_t b);
    logic signed [DW:0] sum;
    sum = {a[DW-1], a} + {b[DW-1], b};
    if (sum[DW] != sum[DW-1]) begin
      if (sum[DW]) return vth_t'({1'b1, {(DW-1){1'b0}}});
      else         return vth_t'({1'b0, {(DW-1){1'b1}}});
    end
    return sum[DW-1:0];
  endfunction

  // Read level = number of references the voltage is at or above.
  function automatic lvl_t slice_level(vth_t v, refs_t refs);
    lvl_t n;
    vth_t r;
    n = '0;
    for (int k = 0; k < LEVELS-1; k++) begin
      r = refs[k*DW +: DW];
      if (v >= r) n = n + lvl_t'(1);
    end
    return n;
  endfunction

  // Out-of-range written levels read as the top level.
  function automatic lvl_t clamp_level(lvl_t l);
    if (int'(l) > LEVELS-1) return lvl_t'(LEVELS-1);
    return l;
  endfunction

endpackage

// File: rtl/flash_cell_read_channel_if.sv
// Noise input, symbol input and read-result output of the read channel.
// Handshakes: a transfer happens on a rising clk edge where valid && ready are
// both high; the sender holds data stable while valid is high and ready is low.
// grv_valid has no ready: a pair offered while the FIFO is full is dropped and
// reported by a one-cycle grv_drop pulse.
interface flash_cell_read_channel_if;
  import flash_chan_pkg::*;

  logic grv_valid;
  vth_t grv1;
  vth_t grv2;
  logic grv_drop;

  logic sym_valid;
  lvl_t sym_level;
  logic sym_ready;

  logic out_valid;
  logic out_ready;
  lvl_t out_level;
  vth_t out_vth;
  logic out_err;

  modport master (
    output grv_valid, grv1, grv2, sym_valid, sym_level, out_ready,
    input  grv_drop, sym_ready, out_valid, out_level, out_vth, out_err
  );

  modport slave (
    input  grv_valid, grv1, grv2, sym_valid, sym_level, out_ready,
    output grv_drop, sym_ready, out_valid, out_level, out_vth, out_err
  );

endinterface

// File: rtl/flash_cell_read_channel_fifo.sv
// Noise pair FIFO: stores {grv2,grv1} pairs and hands out one sample per consume,
// grv1 first, popping the entry once grv2 has been used.
module noise_pair_fifo
  import flash_chan_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           push_i,
  input  logic [2*DW-1:0] push_data_i,
  input  logic           consume_i,
  output logic           not_empty_o,
  output vth_t           sample_o,
  output logic           drop_o
);

  localparam int PW = (FIFO_PAIRS > 1) ? $clog2(FIFO_PAIRS) : 1;
  localparam int CW = $clog2(FIFO_PAIRS + 1);

  logic [2*DW-1:0] mem_q [FIFO_PAIRS];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            half_q, half_d;
  logic            take;
  logic            pop;
  logic            push_ok;

  function automatic logic [PW-1:0] ptr_inc(logic [PW-1:0] p);
    if (p == PW'(FIFO_PAIRS-1)) return '0;
    return p + PW'(1);
  endfunction

  // Push/pop decisions, pointer and count next-state, half-select toggle.
  always_comb begin
    not_empty_o = (count_q != '0);
    take        = consume_i && not_empty_o;
    pop         = take && half_q;
    // A full FIFO still accepts a pair when the head entry leaves this cycle.
    push_ok     = push_i && ((count_q < CW'(FIFO_PAIRS)) || pop);
    drop_o      = push_i && !push_ok;
    half_d      = take ? !half_q : half_q;
    wr_ptr_d    = push_ok ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d    = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d     = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    sample_o = half_q ? mem_q[rd_ptr_q][2*DW-1:DW] : mem_q[rd_ptr_q][DW-1:0];
  end

  // Control state: pointers, occupancy and half-select.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      half_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      half_q   <= half_d;
    end
  end

  // Pair storage; contents are only meaningful below the occupancy count.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/flash_cell_read_channel.sv
// Flash cell read channel: adds Gaussian noise to the nominal Vth of each written
// level, slices against read references and counts symbols and level errors.
module flash_cell_read_channel
  import flash_chan_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  flash_cell_read_channel_if.slave   bus,
  input  logic [LEVELS*DW-1:0]       lvl_mean,
  input  logic [(LEVELS-1)*DW-1:0]   rd_ref,
  input  logic                       clr_cnt,
  output logic [CNT_W-1:0]           sym_cnt,
  output logic [CNT_W-1:0]           err_cnt
);

  logic       fifo_ne;
  vth_t       noise;
  logic       adv;
  logic       accept;
  logic       out_hs;
  lvl_t       wr_lvl;
  vth_t       mean_arr [LEVELS];

  logic       s1_valid_q, s1_valid_d;
  vth_t       s1_vth_q, s1_vth_d;
  lvl_t       s1_lvl_q, s1_lvl_d;
  logic       s2_valid_q, s2_valid_d;
  vth_t       s2_vth_q, s2_vth_d;
  lvl_t       s2_lvl_q, s2_lvl_d;
  logic       s2_err_q, s2_err_d;
  logic [CNT_W-1:0] sym_cnt_q, sym_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  noise_pair_fifo u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (bus.grv_valid),
    .push_data_i ({bus.grv2, bus.grv1}),
    .consume_i   (accept),
    .not_empty_o (fifo_ne),
    .sample_o    (noise),
    .drop_o      (bus.grv_drop)
  );

  // Unpack the static per-level nominal voltages.
  always_comb begin
    for (int k = 0; k < LEVELS; k++) mean_arr[k] = lvl_mean[k*DW +: DW];
  end

  // Single pipeline enable; S1 only moves when S2 can move, so a stall never consumes noise.
  always_comb begin
    adv           = !s2_valid_q || bus.out_ready;
    bus.sym_ready = adv && fifo_ne;
    accept        = bus.sym_valid && bus.sym_ready;
    out_hs        = s2_valid_q && bus.out_ready;
    wr_lvl        = clamp_level(bus.sym_level);
    s1_valid_d    = s1_valid_q;
    s1_vth_d      = s1_vth_q;
    s1_lvl_d      = s1_lvl_q;
    s2_valid_d    = s2_valid_q;
    s2_vth_d      = s2_vth_q;
    s2_lvl_d      = s2_lvl_q;
    s2_err_d      = s2_err_q;
    if (adv) begin
      s1_valid_d = accept;
      if (accept) begin
        s1_vth_d = sat_add(mean_arr[wr_lvl], noise);
        s1_lvl_d = wr_lvl;
      end
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_vth_d = s1_vth_q;
        s2_lvl_d = slice_level(s1_vth_q, rd_ref);
        s2_err_d = (s2_lvl_d != s1_lvl_q);
      end
    end
  end

  // Saturating counters; clear wins over a same-cycle increment.
  always_comb begin
    sym_cnt_d = sym_cnt_q;
    err_cnt_d = err_cnt_q;
    if (clr_cnt) begin
      sym_cnt_d = '0;
      err_cnt_d = '0;
    end else if (out_hs) begin
      if (sym_cnt_q != '1) sym_cnt_d = sym_cnt_q + CNT_W'(1);
      if (s2_err_q && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  // Pipeline and counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      s1_vth_q   <= '0;
      s1_lvl_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_vth_q   <= '0;
      s2_lvl_q   <= '0;
      s2_err_q   <= 1'b0;
      sym_cnt_q  <= '0;
      err_cnt_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_vth_q   <= s1_vth_d;
      s1_lvl_q   <= s1_lvl_d;
      s2_valid_q <= s2_valid_d;
      s2_vth_q   <= s2_vth_d;
      s2_lvl_q   <= s2_lvl_d;
      s2_err_q   <= s2_err_d;
      sym_cnt_q  <= sym_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign bus.out_valid = s2_valid_q;
  assign bus.out_vth   = s2_vth_q;
  assign bus.out_level = s2_lvl_q;
  assign bus.out_err   = s2_err_q;
  assign sym_cnt       = sym_cnt_q;
  assign err_cnt       = err_cnt_q;

endmodule

// File: tb/tb_flash_cell_read_channel.sv
// Bench for flash_cell_read_channel: a noise model and expected-result queue
// predict every read result; scenario tasks drive stimulus and check inline.
module tb_flash_cell_read_channel;
  import flash_chan_pkg::*;

  localparam int W = DW + LW + 1;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [LEVELS*DW-1:0]     lvl_mean;
  logic [(LEVELS-1)*DW-1:0] rd_ref;
  logic                     clr_cnt;
  logic [CNT_W-1:0]         sym_cnt;
  logic [CNT_W-1:0]         err_cnt;

  flash_cell_read_channel_if bus ();

  flash_cell_read_channel dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .lvl_mean (lvl_mean),
    .rd_ref   (rd_ref),
    .clr_cnt  (clr_cnt),
    .sym_cnt  (sym_cnt),
    .err_cnt  (err_cnt)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Model state and scoreboard
  int             mean_m [LEVELS];
  int             ref_m  [LEVELS-1];
  int             noise_q [$];
  logic [W-1:0]   exp_q [$];
  logic [W-1:0]   mon_ent;
  int             chk_cnt;
  int             pass_cnt;
  int             exp_sym;
  int             exp_err;

  function automatic int m_sat(input int s);
    int hi, lo;
    hi = (1 << (DW-1)) - 1;
    lo = -(1 << (DW-1));
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

  function automatic int m_slice(input int v);
    int n;
    n = 0;
    for (int k = 0; k < LEVELS-1; k++) if (v >= ref_m[k]) n++;
    return n;
  endfunction

  // Output monitor: every output handshake is compared with the queue head.
  always @(negedge clk) begin
    if (reset === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      chk_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL out_unexpected: got vth=%0h lvl=%0d with no result pending",
                 bus.out_vth, bus.out_level);
      end else begin
        mon_ent = exp_q.pop_front();
        if ({bus.out_err, bus.out_level, bus.out_vth} !== mon_ent)
          $display("FAIL out_result: got err=%b lvl=%0d vth=%0h, required err=%b lvl=%0d vth=%0h",
                   bus.out_err, bus.out_level, bus.out_vth,
                   mon_ent[W-1], mon_ent[W-2:DW], mon_ent[DW-1:0]);
        else pass_cnt++;
        exp_sym++;
        exp_err += int'(mon_ent[W-1]);
      end
    end
  end

  // Driver tasks
  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) sync();
  endtask

  task automatic apply_cfg();
    for (int k = 0; k < LEVELS; k++) lvl_mean[k*DW +: DW] = DW'(mean_m[k]);
    for (int k = 0; k < LEVELS-1; k++) rd_ref[k*DW +: DW] = DW'(ref_m[k]);
  endtask

  task automatic push_pair(input logic [DW-1:0] g1, input logic [DW-1:0] g2);
    int   pairs;
    logic exp_drop;
    bus.grv_valid = 1'b1;
    bus.grv1      = g1;
    bus.grv2      = g2;
    pairs         = (noise_q.size() + 1) / 2;
    exp_drop      = (pairs >= FIFO_PAIRS);
    @(negedge clk);
    chk_cnt++;
    if (bus.grv_drop !== exp_drop)
      $display("FAIL grv_drop: got %b, required %b", bus.grv_drop, exp_drop);
    else pass_cnt++;
    if (!exp_drop) begin
      noise_q.push_back(int'($signed(g1)));
      noise_q.push_back(int'($signed(g2)));
    end
    sync();
    bus.grv_valid = 1'b0;
  endtask

  // Offers one symbol (caller is aligned just after a rising edge).
  task automatic send_sym(input int lvl);
    int           guard, n, v, l;
    logic [W-1:0] ent;
    guard         = 0;
    bus.sym_valid = 1'b1;
    bus.sym_level = LW'(lvl);
    @(negedge clk);
    while (bus.sym_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) begin
      chk_cnt++;
      $display("FAIL sym_accept: sym_ready stayed %b, required 1 within 20 cycles", bus.sym_ready);
      sync();
      bus.sym_valid = 1'b0;
      return;
    end
    if (noise_q.size() == 0) begin
      chk_cnt++;
      $display("FAIL sym_ready_empty: got sym_ready=1, required 0 with no noise queued");
      n = 0;
    end else begin
      n = noise_q.pop_front();
    end
    v   = m_sat(mean_m[lvl] + n);
    l   = m_slice(v);
    ent = {(l != lvl), l[LW-1:0], v[DW-1:0]};
    exp_q.push_back(ent);
    sync();
    bus.sym_valid = 1'b0;
  endtask

  // Scenarios
  task automatic test_reset();
    reset         = 1'b0;
    bus.grv_valid = 1'b0;
    bus.grv1      = '0;
    bus.grv2      = '0;
    bus.sym_valid = 1'b0;
    bus.sym_level = '0;
    bus.out_ready = 1'b1;
    clr_cnt       = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk_cnt++;
    if ({bus.out_valid, bus.sym_ready, bus.grv_drop, bus.out_err, bus.out_level} !== '0)
      $display("FAIL reset_ctrl: got valid=%b ready=%b drop=%b err=%b lvl=%0d, required all 0",
               bus.out_valid, bus.sym_ready, bus.grv_drop, bus.out_err, bus.out_level);
    else pass_cnt++;
    chk_cnt++;
    if (bus.out_vth !== '0) $display("FAIL reset_vth: got %0h, required 0", bus.out_vth);
    else pass_cnt++;
    chk_cnt++;
    if (sym_cnt !== '0 || err_cnt !== '0)
      $display("FAIL reset_cnt: got sym=%0d err=%0d, required 0 0", sym_cnt, err_cnt);
    else pass_cnt++;
    sync();
  endtask

  task automatic test_nominal();
    push_pair(16'h0010, 16'hFFF0);
    for (int s = 1; s <= 2; s++) begin
      send_sym(s);
      @(negedge clk);
      chk_cnt++;
      if (bus.out_valid !== 1'b0) $display("FAIL latency_early: got out_valid=%b, required 0", bus.out_valid);
      else pass_cnt++;
      @(negedge clk);
      chk_cnt++;
      if (bus.out_valid !== 1'b1) $display("FAIL latency_2: got out_valid=%b, required 1", bus.out_valid);
      else pass_cnt++;
      sync();
    end
    @(negedge clk);
    chk_cnt++;
    if (bus.sym_ready !== 1'b0) $display("FAIL empty_ready: got %b, required 0", bus.sym_ready);
    else pass_cnt++;
    sync();
  endtask

  task automatic test_saturation();
    mean_m[0] = 32'h7FF0;
    apply_cfg();
    push_pair(16'h0100, 16'h0000);
    send_sym(0);
    send_sym(3);
    idle(4);
    @(negedge clk);
    chk_cnt++;
    if (sym_cnt !== CNT_W'(exp_sym) || err_cnt !== CNT_W'(exp_err))
      $display("FAIL sat_counts: got sym=%0d err=%0d, required %0d %0d", sym_cnt, err_cnt, exp_sym, exp_err);
    else pass_cnt++;
    sync();
    mean_m[0] = 0;
    apply_cfg();
  endtask

  task automatic test_fifo_fill();
    for (int p = 0; p < 5; p++) push_pair(DW'($urandom_range(0, 16'hFFFF)), DW'($urandom_range(0, 16'hFFFF)));
    for (int s = 0; s < 8; s++) send_sym($urandom_range(0, LEVELS-1));
    @(negedge clk);
    chk_cnt++;
    if (bus.sym_ready !== 1'b0) $display("FAIL fill_drained: got sym_ready=%b, required 0", bus.sym_ready);
    else pass_cnt++;
    sync();
    idle(4);
    @(negedge clk);
    chk_cnt++;
    if (sym_cnt !== CNT_W'(exp_sym) || err_cnt !== CNT_W'(exp_err))
      $display("FAIL fill_counts: got sym=%0d err=%0d, required %0d %0d", sym_cnt, err_cnt, exp_sym, exp_err);
    else pass_cnt++;
    sync();
  endtask

  task automatic test_stall();
    push_pair(DW'($urandom_range(0, 16'h0FFF)), DW'($urandom_range(0, 16'h0FFF)));
    push_pair(DW'($urandom_range(0, 16'h0FFF)), DW'($urandom_range(0, 16'h0FFF)));
    bus.out_ready = 1'b0;
    send_sym(0);
    send_sym(1);
    bus.sym_valid = 1'b1;
    bus.sym_level = LW'(2);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk_cnt++;
      if (bus.sym_ready !== 1'b0) $display("FAIL stall_ready: got %b, required 0", bus.sym_ready);
      else pass_cnt++;
      chk_cnt++;
      if (bus.out_valid !== 1'b1 || {bus.out_err, bus.out_level, bus.out_vth} !== exp_q[0])
        $display("FAIL stall_hold: got valid=%b data=%0h, required 1 %0h",
                 bus.out_valid, {bus.out_err, bus.out_level, bus.out_vth}, exp_q[0]);
      else pass_cnt++;
    end
    sync();
    bus.sym_valid = 1'b0;
    bus.out_ready = 1'b1;
    send_sym(2);
    send_sym(3);
    idle(4);
    @(negedge clk);
    chk_cnt++;
    if (exp_q.size() != 0 || bus.sym_ready !== 1'b0)
      $display("FAIL stall_release: got pending=%0d sym_ready=%b, required 0 0", exp_q.size(), bus.sym_ready);
    else pass_cnt++;
    sync();
  endtask

  task automatic test_clear_and_reset();
    push_pair(16'h0800, 16'h0000);
    send_sym(0);
    sync();
    clr_cnt = 1'b1;
    @(negedge clk);
    chk_cnt++;
    if (bus.out_valid !== 1'b1 || bus.out_err !== 1'b1)
      $display("FAIL clr_handshake: got valid=%b err=%b, required 1 1", bus.out_valid, bus.out_err);
    else pass_cnt++;
    sync();
    clr_cnt = 1'b0;
    exp_sym = 0;
    exp_err = 0;
    @(negedge clk);
    chk_cnt++;
    if (sym_cnt !== '0 || err_cnt !== '0)
      $display("FAIL clr_priority: got sym=%0d err=%0d, required 0 0", sym_cnt, err_cnt);
    else pass_cnt++;
    sync();
    push_pair(16'h0010, 16'h0020);
    send_sym(1);
    send_sym(2);
    exp_q.delete();
    noise_q.delete();
    reset = 1'b0;
    #1;
    chk_cnt++;
    if (bus.out_valid !== 1'b0 || bus.sym_ready !== 1'b0 || sym_cnt !== '0)
      $display("FAIL async_reset: got valid=%b ready=%b sym=%0d, required 0 0 0",
               bus.out_valid, bus.sym_ready, sym_cnt);
    else pass_cnt++;
    sync();
    reset = 1'b1;
    @(negedge clk);
    chk_cnt++;
    if (bus.out_valid !== 1'b0 || bus.sym_ready !== 1'b0)
      $display("FAIL post_reset: got valid=%b ready=%b, required 0 0", bus.out_valid, bus.sym_ready);
    else pass_cnt++;
    sync();
    push_pair(16'h0030, 16'h0040);
    send_sym(0);
    idle(4);
    @(negedge clk);
    chk_cnt++;
    if (sym_cnt !== CNT_W'(exp_sym) || err_cnt !== CNT_W'(exp_err))
      $display("FAIL reset_counts: got sym=%0d err=%0d, required %0d %0d", sym_cnt, err_cnt, exp_sym, exp_err);
    else pass_cnt++;
    sync();
  endtask

  // Sequence and report
  initial begin
    chk_cnt  = 0;
    pass_cnt = 0;
    exp_sym  = 0;
    exp_err  = 0;
    mean_m   = '{0, 1000, 2000, 3000};
    ref_m    = '{500, 1500, 2500};
    apply_cfg();
    test_reset();
    test_nominal();
    test_saturation();
    test_fifo_fill();
    test_stall();
    test_clear_and_reset();
    idle(4);
    chk_cnt++;
    if (exp_q.size() != 0) $display("FAIL drain: got %0d results pending, required 0", exp_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
